// File: rtl/adder_8bit.sv
// Registered WIDTH-bit adder with carry-in, carry-out and signed status flags.
// Define ADDER_8BIT_PIPE2_EN to split the add into two half-width stages (latency 2).
module adder_8bit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  logic             resValid;
  logic [WIDTH:0]   resFull;
  logic             resAMsb;
  logic             resBMsb;

  logic             valid_q;
  logic [WIDTH-1:0] sum_q,      sum_d;
  logic             cout_q,     cout_d;
  logic             overflow_q, overflow_d;
  logic             zero_q,     zero_d;

`ifdef ADDER_8BIT_PIPE2_EN
  localparam int H = WIDTH / 2;

  logic         s1Valid_q;
  logic [H-1:0] loSum_q,   loSum_d;
  logic         loCarry_q, loCarry_d;
  logic [H-1:0] aHi_q;
  logic [H-1:0] bHi_q;
  logic [H:0]   hiFull;

  always_comb begin
    {loCarry_d, loSum_d} = {1'b0, a[H-1:0]} + {1'b0, b[H-1:0]} + {{H{1'b0}}, cin};
  end

  // Stage 1: low half sum and carry; upper operand halves ride along for stage 2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1Valid_q <= 1'b0;
      loSum_q   <= '0;
      loCarry_q <= 1'b0;
      aHi_q     <= '0;
      bHi_q     <= '0;
    end else begin
      s1Valid_q <= in_valid;
      if (in_valid) begin
        loSum_q   <= loSum_d;
        loCarry_q <= loCarry_d;
        aHi_q     <= a[WIDTH-1:H];
        bHi_q     <= b[WIDTH-1:H];
      end
    end
  end

  always_comb begin
    hiFull   = {1'b0, aHi_q} + {1'b0, bHi_q} + {{H{1'b0}}, loCarry_q};
    resValid = s1Valid_q;
    resFull  = {hiFull, loSum_q};
    resAMsb  = aHi_q[H-1];
    resBMsb  = bHi_q[H-1];
  end
`else
  always_comb begin
    resValid = in_valid;
    resFull  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    resAMsb  = a[WIDTH-1];
    resBMsb  = b[WIDTH-1];
  end
`endif

  // Flags are all derived from the same result word so they stay coherent with sum.
  always_comb begin
    sum_d      = resFull[WIDTH-1:0];
    cout_d     = resFull[WIDTH];
    overflow_d = (resAMsb == resBMsb) && (sum_d[WIDTH-1] != resAMsb);
    zero_d     = (sum_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= 1'b0;
      sum_q      <= '0;
      cout_q     <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      valid_q <= resValid;
      if (resValid) begin
        sum_q      <= sum_d;
        cout_q     <= cout_d;
        overflow_q <= overflow_d;
        zero_q     <= zero_d;
      end
    end
  end

  assign out_valid = valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_adder_8bit.sv
// Self-checking bench for adder_8bit: directed vectors, streaming, resets and
// random traffic compared against an arithmetic reference model.
module tb_adder_8bit;

`ifdef ADDER_8BIT_PIPE2_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       out_valid;
  logic [7:0] sum;
  logic       cout;
  logic       overflow;
  logic       zero;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit v;
    int sumV;
    bit coutV;
    bit ovV;
    bit zeroV;
  } entry_t;

  entry_t pipeQ[$];
  bit     expValid;
  int     expSum;
  bit     expCout;
  bit     expOv;
  bit     expZero;

  adder_8bit #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .out_valid(out_valid),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow),
    .zero     (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: true integer sum, and signed overflow as "result out of int8 range".
  function automatic entry_t refModel(bit v, logic [7:0] av, logic [7:0] bv, bit c);
    entry_t e;
    int s;
    int sa;
    int sb;
    int ss;
    e = '{v: v, sumV: 0, coutV: 0, ovV: 0, zeroV: 0};
    if (v) begin
      s  = int'(av) + int'(bv) + int'(c);
      sa = (int'(av) >= 128) ? int'(av) - 256 : int'(av);
      sb = (int'(bv) >= 128) ? int'(bv) - 256 : int'(bv);
      ss = sa + sb + int'(c);
      e.sumV  = s % 256;
      e.coutV = (s > 255);
      e.ovV   = (ss > 127) || (ss < -128);
      e.zeroV = ((s % 256) == 0);
    end
    return e;
  endfunction

  task automatic modelReset();
    pipeQ.delete();
    expValid = 0;
    expSum   = 0;
    expCout  = 0;
    expOv    = 0;
    expZero  = 0;
  endtask

  task automatic checkOutput(string tag);
    total++;
    assert (out_valid === expValid) else begin
      bad++;
      $error("FAIL %s out_valid observed=%0b expected=%0b", tag, out_valid, expValid);
    end
    total++;
    assert (sum === 8'(expSum)) else begin
      bad++;
      $error("FAIL %s sum observed=%02h expected=%02h", tag, sum, 8'(expSum));
    end
    total++;
    assert (cout === expCout) else begin
      bad++;
      $error("FAIL %s cout observed=%0b expected=%0b", tag, cout, expCout);
    end
    total++;
    assert (overflow === expOv) else begin
      bad++;
      $error("FAIL %s overflow observed=%0b expected=%0b", tag, overflow, expOv);
    end
    total++;
    assert (zero === expZero) else begin
      bad++;
      $error("FAIL %s zero observed=%0b expected=%0b", tag, zero, expZero);
    end
  endtask

  task automatic checkConst(string tag, logic [7:0] s, bit c, bit o, bit z);
    logic [11:0] obs;
    logic [11:0] req;
    obs = {out_valid, sum, cout, overflow, zero};
    req = {1'b1, s, c, o, z};
    total++;
    assert (obs === req) else begin
      bad++;
      $error("FAIL %s {valid,sum,cout,ovf,zero} observed=%03h expected=%03h", tag, obs, req);
    end
  endtask

  // Drive at the falling edge, advance the model at the rising edge, check at the next falling edge.
  task automatic applyStimulus(bit v, logic [7:0] av, logic [7:0] bv, bit c, string tag);
    entry_t e;
    in_valid = v;
    a        = av;
    b        = bv;
    cin      = c;
    @(posedge clk);
    pipeQ.push_back(refModel(v, av, bv, c));
    if (pipeQ.size() >= LAT) begin
      e = pipeQ.pop_front();
      expValid = e.v;
      if (e.v) begin
        expSum  = e.sumV;
        expCout = e.coutV;
        expOv   = e.ovV;
        expZero = e.zeroV;
      end
    end else begin
      expValid = 0;
    end
    @(negedge clk);
    checkOutput(tag);
  endtask

  task automatic directed(logic [7:0] av, logic [7:0] bv, bit c,
                          logic [7:0] s, bit co, bit o, bit z, string tag);
    applyStimulus(1'b1, av, bv, c, tag);
    repeat (LAT - 1) applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, tag);
    checkConst(tag, s, co, o, z);
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    a        = 8'h00;
    b        = 8'h00;
    cin      = 1'b0;
    modelReset();
    @(negedge clk);
    checkOutput("reset_state");
    rst = 1'b0;
    repeat (2) applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, "idle_after_reset");

    directed(8'h02, 8'h03, 1'b0, 8'h05, 1'b0, 1'b0, 1'b0, "add_2_3");
    directed(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, "add_1_1");
    directed(8'h19, 8'h31, 1'b0, 8'h4A, 1'b0, 1'b0, 1'b0, "add_19_31");
    directed(8'h81, 8'h81, 1'b0, 8'h02, 1'b1, 1'b1, 1'b0, "add_81_81");
    directed(8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0, "add_ff_ff");
    directed(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, "wrap_ff_01");
    directed(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, "zero_00_00");
    directed(8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1, 1'b0, "ovf_7f_cin");
    directed(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, "max_ff_ff_1");

    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), "stream_valid");
      applyStimulus(1'b0, 8'hA5, 8'h5A, 1'b1, "stream_gap");
    end
    repeat (LAT) applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, "stream_drain");

    // Asynchronous reset asserted mid-cycle while valid traffic is in flight.
    repeat (3) applyStimulus(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), "pre_reset");
    in_valid = 1'b1;
    a        = 8'h11;
    b        = 8'h22;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    modelReset();
    checkOutput("rst_async_mid");
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_held");
    in_valid = 1'b0;
    rst      = 1'b0;
    repeat (3) applyStimulus(1'b0, 8'h33, 8'h44, 1'b0, "post_reset_idle");

    // Reset released in the same cycle that in_valid is high.
    rst = 1'b1;
    #1;
    modelReset();
    @(negedge clk);
    rst = 1'b0;
    directed(8'h40, 8'h02, 1'b0, 8'h42, 1'b0, 1'b0, 1'b0, "rst_release_valid");

    for (int i = 0; i < 10000; i++) begin
      bit v;
      v = 1'($urandom);
      if (v)
        applyStimulus(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), "random");
      else
        applyStimulus(1'b0, 8'bx, 8'bx, 1'bx, "random_idle");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adder_8bit.md
Name: adder_8bit

Overview:
- 8-bit binary adder with carry-in.
- Produces an 8-bit sum, carry-out and signed status flags in registered outputs.
- Valid-qualified, so it can sit as a one-cycle arithmetic stage in a datapath.
- Optional macro splits the add into two nibble stages for timing closure.

Parameters:
- WIDTH, 8, operand and sum width in bits. Must be even and ≥ 2. Only 8 is verified.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  qualifies a, b and cin in this cycle.
- a  input  WIDTH  operand A, unsigned or two's complement.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in.
- out_valid  output  1  high for one cycle per accepted input, after the pipeline latency.
- sum  output  WIDTH  (a + b + cin) mod 2^WIDTH.
- cout  output  1  carry out of the MSB.
- overflow  output  1  signed overflow: a[MSB] == b[MSB] and sum[MSB] != a[MSB].
- zero  output  1  high when sum == 0.

Behaviour:
- Clock and reset: one clock (clk). rst is asynchronous and active-high. While rst is high, all outputs are forced to 0 immediately: out_valid=0, sum=0, cout=0, overflow=0, zero=0.
- Arithmetic:
  - {cout, sum} = a + b + cin, computed at WIDTH+1 bits. No saturation.
  - Wrap-around is intended, e.g. 0xFF+0x01+0 gives sum=0x00, cout=1.
  - Maximum case: 0xFF+0xFF+1 gives sum=0xFF, cout=1.
- Base latency is 1 cycle. On the rising edge where in_valid=1, sum, cout, overflow and zero capture the result, and out_valid goes to 1 in the next cycle.
- in_valid=0: out_valid goes to 0 at the next edge. sum, cout, overflow and zero hold their last values; they do not clear.
- Throughput is one result per cycle. There is no backpressure and no ready signal, and back-to-back valid inputs are all accepted.
- Reset mid-operation: in-flight results are discarded. The first valid result after rst deasserts comes from the first in_valid sampled after deassertion.
- Reset deasserted while in_valid is high in the same cycle: the input is sampled at the next rising edge as normal.
- X on a, b or cin while in_valid=0 must not propagate to the outputs, because the data registers are only enabled by in_valid.
- Flags are derived from the same registered result, so they are always coherent with sum.

Optional Feature:
- Macro ADDER_8BIT_PIPE2_EN.
- Defined:
  - Two-stage pipeline, latency 2.
  - Stage 1 registers the low-half sum, the low-half carry, and the upper halves of a and b, with a valid bit.
  - Stage 2 adds the upper halves with the registered carry and registers the full result and flags.
  - out_valid follows in_valid by 2 cycles, and throughput stays one per cycle.
  - Reset clears both stages.
- Undefined: single-stage behaviour as described above, with latency 1.
- Results are bit-identical in both builds; only latency differs.

Test Plan:
- Reset: assert rst asynchronously mid-cycle with valid traffic → all outputs go to 0 immediately. After release with in_valid=0, out_valid stays 0.
- Basic adds:
  - a=0x02, b=0x03, cin=0 → sum=0x05, cout=0, overflow=0, zero=0.
  - a=0x01, b=0x01, cin=0 → sum=0x02.
  - a=0x19, b=0x31 → sum=0x4A, cout=0.
- Carry and overflow:
  - a=0x81, b=0x81, cin=0 → sum=0x02, cout=1, overflow=1.
  - a=0xFF, b=0xFF, cin=0 → sum=0xFE, cout=1, overflow=0.
- Wrap and zero:
  - a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1, zero=1, overflow=0.
  - a=0x00, b=0x00, cin=0 → zero=1, cout=0.
  - a=0x7F, b=0x00, cin=1 → sum=0x80, overflow=1.
- Streaming: drive 6 back-to-back valid vectors with a one-cycle in_valid gap between them → out_valid pattern equals the in_valid pattern delayed by the latency (1, or 2 with ADDER_8BIT_PIPE2_EN). Outputs hold during gaps.
- Randomized: 10k random a, b, cin with in_valid toggling randomly → results match the reference model {cout, sum} = a + b + cin in both macro builds.
